// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch port and the data port, one transaction at a time.
// The data port has priority; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                grant_i, grant_d;
  logic                bus_we_q;
  logic [STRB_W-1:0]   bus_wstrb_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  // Grants exist only in IDLE, so a request finishing in RESP is never granted twice.
  always_comb begin
    grant_d = (state_q == IDLE) && d_req && !(i_req && (starve_q == CNT_MAX));
    grant_i = (state_q == IDLE) && i_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I:  if (bus_ack) state_d = RESP_I;
      BUSY_D:  if (bus_ack) state_d = RESP_D;
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req = (state_q == BUSY_I) || (state_q == BUSY_D);
    i_ready = (state_q == RESP_I);
    d_ready = (state_q == RESP_D);
  end

  // Counts data grants that overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (grant_d) begin
      if (!i_req)                   starve_d = '0;
      else if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    end else if (grant_i) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      starve_q <= starve_d;
      if (grant_d) begin
        bus_we_q    <= d_we;
        bus_wstrb_q <= d_wstrb;
        bus_addr_q  <= d_addr;
        bus_wdata_q <= d_wdata;
      end else if (grant_i) begin
        bus_we_q    <= 1'b0;
        bus_wstrb_q <= '0;
        bus_addr_q  <= i_addr;
        bus_wdata_q <= '0;
      end
      if ((state_q == BUSY_I) && bus_ack) i_rdata_q <= bus_rdata;
      // Stores complete without disturbing the last load result.
      if ((state_q == BUSY_D) && bus_ack && !bus_we_q) d_rdata_q <= bus_rdata;
    end
  end

  assign bus_we    = bus_we_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single shared memory bus between the instruction-fetch port (IF stage, read-only) and the data port (MEM stage, load/store). It allows one outstanding transaction at a time and gives the data port fixed priority. A starvation guard ensures a continuously requesting fetch port is eventually served. Each port's `~x_ready` is the stall source for its pipeline stage while that port's request is pending.

## Interface
- `ADDR_W`, 32, address width of ports and bus
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `STARVE_LIMIT`, 4, maximum consecutive data grants while fetch is waiting; legal range ≥1

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_ready`
- `i_addr`  in  ADDR_W  fetch address
- `i_ready`  out  1  one-cycle pulse, fetch done; `i_rdata` valid in that cycle
- `i_rdata`  out  DATA_W  fetched word
- `d_req`  in  1  data request; held with attributes stable until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_wstrb`  in  DATA_W/8  store byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ready`  out  1  one-cycle pulse, data access done
- `d_rdata`  out  DATA_W  load data; updated on loads only
- `bus_req`  out  1  bus transaction active; held until `bus_ack`
- `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata`  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction attributes, stable while `bus_req` is high
- `bus_ack`  in  1  memory completion; may be asserted in the first `bus_req` cycle
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`

## Operation
- States are IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
- **IDLE.** Grant decision, evaluated only in this state:
  - Neither port requesting: stay in IDLE.
  - Only one port requesting: grant it.
  - Both requesting: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
  - On grant, latch the winner's attributes into the bus registers, set `bus_req=1`, and go to BUSY_x.
  - A fetch grant forces `bus_we=0` and `bus_wstrb=0`.
- **BUSY_x.** Hold all bus outputs.
  - On `bus_ack`: drop `bus_req`, capture `bus_rdata` into `x_rdata` (data port: loads only), go to RESP_x.
- **RESP_x.** Assert `x_ready=1` for exactly this cycle, then go to IDLE.
  - The requester updates or drops its request at this edge.
  - No grant is made in RESP, so a completed request can never be re-granted.
- **starve_cnt** (width `$clog2(STARVE_LIMIT+1)`):
  - On a data grant with `i_req=1`: increment, saturating at `STARVE_LIMIT`.
  - On a data grant with `i_req=0`: clear.
  - On any fetch grant: clear.
- Request or attribute changes while not yet granted are legal and are sampled only in IDLE. Changes after grant are ignored because the attributes are latched.
- Store completion gives `d_ready` with `d_rdata` unchanged.

## Timing
- **Reset values:** state IDLE, `starve_cnt=0`, and every output 0 (`bus_req`, `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`).
- **Reset mid-transaction:** the cycle after reset sees `bus_req=0` and no ready pulse. The in-flight access is abandoned, and the memory side is reset by the same `reset`.
- **Minimum latency:** request seen in IDLE at cycle 0 → `bus_req` in cycle 1 → `bus_ack` in cycle 1 → `x_ready` in cycle 2 → IDLE in cycle 3. Peak throughput is 1 transfer per 3 cycles.
- **With memory wait states:** `x_ready` occurs 1 cycle after the `bus_ack` cycle.
- **Mutual exclusion:** `i_ready` and `d_ready` are never high in the same cycle.
- **bus_ack outside BUSY:** ignored.

## Test plan
- **Single fetch, zero-wait memory.** `i_req=1`, `i_addr=0x100`; memory acks in the first `bus_req` cycle with `0x00500093` → `bus_req` high for 1 cycle with `bus_addr=0x100` and `bus_we=0`; `i_ready` in cycle 2 with `i_rdata=0x00500093`; IDLE in cycle 3.
- **Store with 3 wait states.** `d_req=1`, `d_we=1`, `d_addr=0x2004`, `d_wstrb=4'b0011`, `d_wdata=0xDEADBEEF`; ack after 3 cycles → bus attributes stable for 4 cycles; `d_ready` pulses once; `d_rdata` unchanged.
- **Simultaneous requests, priority.** `i_req` and `d_req` both rise at cycle 0, with a fetch at `0x10` and a load at `0x2000` → data granted first; fetch granted in the next IDLE; `starve_cnt` goes 1 then 0.
- **Starvation guard.** `i_req` held high; `d_req` re-asserted immediately after every `d_ready`; `STARVE_LIMIT=4` → 4 data grants, then a fetch grant, then the data port is served again.
- **Reset mid-operation.** Assert `reset` while in BUSY_D with a load pending → next cycle all outputs 0 and no `d_ready`; a fresh `d_req` after reset completes normally.
- **Back-to-back fetches.** The requester updates `i_addr` (`0x0` → `0x4` → `0x8`) on each `i_ready` → each address appears on the bus exactly once, with no duplicate grant in any RESP cycle.
